// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: frame length limits, inter-frame gap and the
// scheduler state encoding used by the encapsulator and its utilities.
package eth_pkg;

    localparam int LEN_W           = 16;
    localparam int LEN_MAX_PAYLOAD = 1500;
    localparam int IFG_BYTES       = 12;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        START,
        WAIT_DONE,
        IFG
    } sched_state_t;

    // Increment an index modulo n (n requesters numbered 0..n-1).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/eth_tx_scheduler_if.sv
// Bundle between the payload requesters, the TX scheduler and the frame
// encapsulation engine. The scheduler uses the slave view.
interface eth_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = eth_pkg::LEN_W
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic                     frame_start;
    logic [LEN_W-1:0]         frame_len;
    logic                     eng_tx_en;
    logic                     frame_done;
    logic                     ifg_active;
    logic                     err_len;
    logic                     err_timeout;

    // Requesters plus engine side.
    modport master (
        output req,
        output req_len,
        output frame_done,
        input  grant,
        input  frame_start,
        input  frame_len,
        input  eng_tx_en,
        input  ifg_active,
        input  err_len,
        input  err_timeout
    );

    // Scheduler side.
    modport slave (
        input  req,
        input  req_len,
        input  frame_done,
        output grant,
        output frame_start,
        output frame_len,
        output eng_tx_en,
        output ifg_active,
        output err_len,
        output err_timeout
    );

endinterface

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping to 0. Returns the winner one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);

    always_comb begin : p_pick
        logic [PW-1:0] j;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = PW'((int'(ptr) + k) % N);
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one frame-encapsulation engine between
// NUM_REQ payload buffers: length check, frame handshake, watchdog and IFG.
module eth_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LEN_W       = eth_pkg::LEN_W,
    parameter int MAX_PAYLOAD = eth_pkg::LEN_MAX_PAYLOAD,
    parameter int IFG_CYCLES  = eth_pkg::IFG_BYTES,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic               clk,
    input logic               rst,
    eth_tx_scheduler_if.slave bus
);

    import eth_pkg::sched_state_t;
    import eth_pkg::IDLE;
    import eth_pkg::ARB;
    import eth_pkg::START;
    import eth_pkg::WAIT_DONE;
    import eth_pkg::IFG;
    import eth_pkg::wrap_inc;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_PAYLOAD);

    sched_state_t       state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx_q, win_idx_d;
    logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               frame_start_q, frame_start_d;
    logic               eng_tx_en_q, eng_tx_en_d;
    logic               ifg_active_q, ifg_active_d;
    logic               err_len_q, err_len_d;
    logic               err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [LEN_W-1:0]   len_arr [NUM_REQ];
    logic               len_bad;
    logic               wd_expired;
    logic [PTR_W-1:0]   nxt_ptr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
        assign len_arr[i] = bus.req_len[i*LEN_W +: LEN_W];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PTR_W)
    ) u_rr_arbiter (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (arb_oh),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Length is checked on the latched copy, so a requester changing req_len
    // after the IDLE sample cannot affect the accepted frame.
    assign len_bad    = (frame_len_q == '0) || ({1'b0, frame_len_q} > MAX_LEN);
    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign nxt_ptr    = PTR_W'(wrap_inc(int'(win_idx_q), NUM_REQ));

    always_comb begin
        // NOTE: every _d takes its hold or idle value before the case, so no
        // path through the decode leaves a signal unassigned (no latches).
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_idx_d     = win_idx_q;
        win_oh_d      = win_oh_q;
        frame_len_d   = frame_len_q;
        wd_d          = wd_q;
        ifg_d         = ifg_q;
        grant_d       = '0;
        frame_start_d = 1'b0;
        eng_tx_en_d   = 1'b0;
        ifg_active_d  = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_idx_d   = arb_idx;
                    win_oh_d    = arb_oh;
                    frame_len_d = len_arr[arb_idx];
                    state_d     = ARB;
                end
            end

            ARB: begin
                if (len_bad) begin
                    err_len_d = 1'b1;
                    ptr_d     = nxt_ptr;
                    state_d   = IDLE;
                end else begin
                    grant_d     = win_oh_q;
                    eng_tx_en_d = 1'b1;
                    wd_d        = '0;
                    state_d     = START;
                end
            end

            START: begin
                grant_d       = win_oh_q;
                frame_start_d = 1'b1;
                eng_tx_en_d   = 1'b1;
                state_d       = WAIT_DONE;
            end

            WAIT_DONE: begin
                // frame_done takes priority over a watchdog expiring the same cycle.
                if (bus.frame_done || wd_expired) begin
                    err_timeout_d = !bus.frame_done;
                    ptr_d         = nxt_ptr;
                    ifg_d         = '0;
                    ifg_active_d  = 1'b1;
                    state_d       = IFG;
                end else begin
                    wd_d        = wd_q + WD_W'(1);
                    grant_d     = win_oh_q;
                    eng_tx_en_d = 1'b1;
                end
            end

            IFG: begin
                if (ifg_q == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    ifg_d        = ifg_q + IFG_W'(1);
                    ifg_active_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of its _d regardless of statement order.
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_idx_q     <= '0;
            win_oh_q      <= '0;
            frame_len_q   <= '0;
            wd_q          <= '0;
            ifg_q         <= '0;
            grant_q       <= '0;
            frame_start_q <= 1'b0;
            eng_tx_en_q   <= 1'b0;
            ifg_active_q  <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_idx_q     <= win_idx_d;
            win_oh_q      <= win_oh_d;
            frame_len_q   <= frame_len_d;
            wd_q          <= wd_d;
            ifg_q         <= ifg_d;
            grant_q       <= grant_d;
            frame_start_q <= frame_start_d;
            eng_tx_en_q   <= eng_tx_en_d;
            ifg_active_q  <= ifg_active_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.eng_tx_en   = eng_tx_en_q;
    assign bus.ifg_active  = ifg_active_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_timeout = err_timeout_q;

endmodule
